// File: rtl/ktms_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ktms_mmio_pkg
// Description : Definitions shared by the AFU MMIO request issuer and the
//               MMIO ack aggregator: broadcast address bus field offsets,
//               the request-issuer state encoding, the forced-response data
//               word and the host read-data formatting rule.
// Revision    : 1.0 - initial release
// ============================================================================
package ktms_mmio_pkg;

  // Bit offsets of the fields packed onto the broadcast address bus.
  // The address occupies [c_abus_addr +: mmio_addr_width].
  localparam int c_abus_vld  = 0;
  localparam int c_abus_cfg  = 1;
  localparam int c_abus_rnw  = 2;
  localparam int c_abus_dw   = 3;
  localparam int c_abus_addr = 4;

  // Data returned to the host when no register unit answers in time.
  localparam logic [63:0] c_timeout_data = 64'hFFFF_FFFF_FFFF_FFFF;

  // Request issuer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mmio_state_t;

  // Host read-data formatting.
  // Host bit numbering is big-endian ([0:63]), so the host's bits 32..63
  // are the low word [31:0] of our little-endian vector. A 32-bit read
  // returns that word replicated into both halves; writes return zero.
  function automatic logic [63:0] fmt_rdata(
    input logic        rnw,
    input logic        dw,
    input logic [63:0] d
  );
    logic [63:0] w_res;
    if (!rnw) begin
      w_res = 64'd0;
    end else if (dw) begin
      w_res = d;
    end else begin
      w_res = {d[31:0], d[31:0]};
    end
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ktms_afu_mmio_tmr.sv
`default_nettype none
// ============================================================================
// Module      : ktms_afu_mmio_tmr
// Description : Wait-state timer for the MMIO request issuer. A
//               log2(timeout_cycles)-bit up-counter with synchronous clear
//               and count enable. o_expire is asserted while enabled and the
//               count sits at timeout_cycles-1, i.e. during the
//               timeout_cycles-th enabled cycle after a clear.
// Ports       : clk      - clock
//               reset    - asynchronous active-low reset
//               i_clr    - clear count to zero (wins over i_en)
//               i_en     - advance count by one
//               o_expire - final count reached while enabled
// Revision    : 1.0 - initial release
// ============================================================================
module ktms_afu_mmio_tmr #(
  // Must be a power of two and at least 4.
  parameter int timeout_cycles = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int c_tw = $clog2(timeout_cycles);

  logic [c_tw-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + c_tw'(1);
    end
  end

  // timeout_cycles is a power of two, so timeout_cycles-1 is all ones and
  // the counter never needs an explicit wrap.
  assign o_expire = i_en & (&r_count);

endmodule
`default_nettype wire

// File: rtl/ktms_afu_mmio_req.sv
`default_nettype none
// ============================================================================
// Module      : ktms_afu_mmio_req
// Description : Host-facing MMIO request issuer. Accepts one host MMIO
//               request at a time, broadcasts it to all register units as a
//               one-cycle pulse on the address/data bus, waits for the
//               aggregated acknowledge and returns ack plus read data to the
//               host. A wait-state timer forces an all-ones response so the
//               host is never left hanging.
// Ports       : clk          - clock
//               reset        - asynchronous active-low reset
//               ha_mmval     - host request valid (single-cycle pulse)
//               ha_mmcfg     - config-space access
//               ha_mmrnw     - 1 read / 0 write
//               ha_mmdw      - 1 64-bit / 0 32-bit access
//               ha_mmad      - request address
//               ha_mmdata    - write data
//               o_mmioabus   - broadcast bus {addr,dw,rnw,cfg,vld}
//               o_mmiodbus   - broadcast write data
//               i_ack_v      - aggregated acknowledge
//               i_ack_d      - aggregated read data
//               ah_mmack     - host acknowledge (single-cycle pulse)
//               ah_mmdata    - host read data, valid with ah_mmack
//               o_timeout    - pulse when a response is forced
//               o_proto_err  - pulse when a request arrives while busy
//               o_stray_ack  - pulse when an ack arrives while idle
// Revision    : 1.0 - initial release
// ============================================================================
module ktms_afu_mmio_req
  import ktms_mmio_pkg::*;
#(
  parameter int mmio_addr_width = 24,
  parameter int mmiobus_awidth  = mmio_addr_width + 4,
  // Must be a power of two and at least 4.
  parameter int timeout_cycles  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  // host request
  input  logic                       ha_mmval,
  input  logic                       ha_mmcfg,
  input  logic                       ha_mmrnw,
  input  logic                       ha_mmdw,
  input  logic [mmio_addr_width-1:0] ha_mmad,
  input  logic [63:0]                ha_mmdata,
  // broadcast to register units
  output logic [mmiobus_awidth-1:0]  o_mmioabus,
  output logic [63:0]                o_mmiodbus,
  // aggregated acknowledge
  input  logic                       i_ack_v,
  input  logic [63:0]                i_ack_d,
  // host response
  output logic                       ah_mmack,
  output logic [63:0]                ah_mmdata,
  // status pulses
  output logic                       o_timeout,
  output logic                       o_proto_err,
  output logic                       o_stray_ack
);

  mmio_state_t r_state;
  mmio_state_t w_state_nxt;

  logic [mmiobus_awidth-1:0] r_abus;
  logic [63:0]               r_dbus;
  logic                      r_mmack;
  logic [63:0]               r_mmdata;
  logic                      r_timeout;
  logic                      r_proto_err;
  logic                      r_stray_ack;

  logic w_accept;    // request taken in IDLE
  logic w_ack_take;  // ack consumed in WAIT
  logic w_force;     // timer expired with no ack
  logic w_respond;   // WAIT -> RESP this cycle
  logic w_expire;

  // --------------------------------------------------------------------------
  // Wait-state timer: cleared during the ISSUE cycle so that it reads zero in
  // the first WAIT cycle, and counts only while waiting.
  // --------------------------------------------------------------------------
  ktms_afu_mmio_tmr #(
    .timeout_cycles (timeout_cycles)
  ) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (r_state == ST_ISSUE),
    .i_en     (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  assign w_accept   = (r_state == ST_IDLE) & ha_mmval;
  assign w_ack_take = (r_state == ST_WAIT) & i_ack_v;
  // An ack landing in the expiry cycle wins; the timeout is suppressed.
  assign w_force    = (r_state == ST_WAIT) & ~i_ack_v & w_expire;
  assign w_respond  = w_ack_take | w_force;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (ha_mmval)  w_state_nxt = ST_ISSUE;
      ST_ISSUE:                w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_respond) w_state_nxt = ST_RESP;
      ST_RESP:                 w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs. Everything is loaded on the edge that enters the
  // state in which it must be visible, so each pulse coincides with its
  // state and no output has a combinational path from an input.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_abus      <= '0;
      r_dbus      <= '0;
      r_mmack     <= 1'b0;
      r_mmdata    <= '0;
      r_timeout   <= 1'b0;
      r_proto_err <= 1'b0;
      r_stray_ack <= 1'b0;
    end else begin
      // vld is high exactly in the ISSUE cycle; the other fields and the
      // data bus keep the last request so receivers see a stable bus.
      r_abus[c_abus_vld] <= w_accept;
      if (w_accept) begin
        r_abus[c_abus_cfg]                      <= ha_mmcfg;
        r_abus[c_abus_rnw]                      <= ha_mmrnw;
        r_abus[c_abus_dw]                       <= ha_mmdw;
        r_abus[c_abus_addr +: mmio_addr_width]  <= ha_mmad;
        r_dbus                                  <= ha_mmdata;
      end

      r_mmack   <= w_respond;
      r_timeout <= w_force;
      if (w_respond) begin
        r_mmdata <= fmt_rdata(r_abus[c_abus_rnw], r_abus[c_abus_dw],
                              w_ack_take ? i_ack_d : c_timeout_data);
      end else begin
        r_mmdata <= '0;
      end

      // A request while busy is dropped; state is untouched.
      r_proto_err <= ha_mmval & (r_state != ST_IDLE);
      // An ack while idle is typically a late answer to a timed-out request.
      r_stray_ack <= i_ack_v & (r_state == ST_IDLE);
    end
  end

  assign o_mmioabus  = r_abus;
  assign o_mmiodbus  = r_dbus;
  assign ah_mmack    = r_mmack;
  assign ah_mmdata   = r_mmdata;
  assign o_timeout   = r_timeout;
  assign o_proto_err = r_proto_err;
  assign o_stray_ack = r_stray_ack;

endmodule
`default_nettype wire

// File: tb/tb_ktms_afu_mmio_req.sv
`default_nettype none
// ============================================================================
// Module      : tb_ktms_afu_mmio_req
// Description : Self-checking bench for ktms_afu_mmio_req: table of directed
//               transactions, hand-written corner sequences (stray ack,
//               request while busy, reset mid-transaction) and a randomized
//               run checked cycle by cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ktms_afu_mmio_req;

  localparam int T  = 64;   // timeout_cycles for this bench
  localparam int AW = 24;
  localparam int BW = AW + 4;
  localparam int N_RAND = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ha_mmval = 1'b0, ha_mmcfg = 1'b0, ha_mmrnw = 1'b0, ha_mmdw = 1'b0;
  logic [AW-1:0] ha_mmad = '0;
  logic [63:0]   ha_mmdata = '0;
  logic [BW-1:0] o_mmioabus;
  logic [63:0]   o_mmiodbus;
  logic          i_ack_v = 1'b0;
  logic [63:0]   i_ack_d = '0;
  logic          ah_mmack;
  logic [63:0]   ah_mmdata;
  logic          o_timeout, o_proto_err, o_stray_ack;

  int n_tests = 0;
  int n_fail  = 0;

  // Last accepted request as the bus should hold it (vld bit excluded).
  logic [BW-1:0] last_abus = '0;
  logic [63:0]   last_dbus = '0;

  typedef struct packed {
    logic [BW-1:0] abus;
    logic [63:0]   dbus;
    logic          ack;
    logic [63:0]   data;
    logic          to;
    logic          perr;
    logic          stray;
  } obs_t;

  typedef struct {
    logic          cfg, rnw, dw;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    int            ack_cyc;   // cycle carrying i_ack_v, -1 for none
    logic [63:0]   ack_d;
    logic [63:0]   exp_data;
    int            exp_resp;  // cycle of ah_mmack (request at cycle 0)
    int            exp_to;
  } vec_t;

  vec_t vecs[8];

  ktms_afu_mmio_req #(
    .mmio_addr_width (AW),
    .mmiobus_awidth  (BW),
    .timeout_cycles  (T)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .ha_mmval    (ha_mmval),
    .ha_mmcfg    (ha_mmcfg),
    .ha_mmrnw    (ha_mmrnw),
    .ha_mmdw     (ha_mmdw),
    .ha_mmad     (ha_mmad),
    .ha_mmdata   (ha_mmdata),
    .o_mmioabus  (o_mmioabus),
    .o_mmiodbus  (o_mmiodbus),
    .i_ack_v     (i_ack_v),
    .i_ack_d     (i_ack_d),
    .ah_mmack    (ah_mmack),
    .ah_mmdata   (ah_mmdata),
    .o_timeout   (o_timeout),
    .o_proto_err (o_proto_err),
    .o_stray_ack (o_stray_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, got no finish, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs();
    obs_t o;
    o.abus  = o_mmioabus;
    o.dbus  = o_mmiodbus;
    o.ack   = ah_mmack;
    o.data  = ah_mmdata;
    o.to    = o_timeout;
    o.perr  = o_proto_err;
    o.stray = o_stray_ack;
    return o;
  endfunction

  // Host data rule: writes return 0, 64-bit reads pass through, 32-bit
  // reads replicate the low word (host bits 32..63).
  function automatic logic [63:0] ref_fmt(input logic rnw, input logic dw, input logic [63:0] d);
    if (!rnw) return 64'd0;
    if (dw)   return d;
    return {2{d[31:0]}};
  endfunction

  // Drive a request for the current cycle and remember what the bus holds.
  task automatic issue(input logic cfg, input logic rnw, input logic dw,
                       input logic [AW-1:0] addr, input logic [63:0] data);
    ha_mmval = 1'b1; ha_mmcfg = cfg; ha_mmrnw = rnw; ha_mmdw = dw;
    ha_mmad = addr; ha_mmdata = data;
    last_abus = {addr, dw, rnw, cfg, 1'b0};
    last_dbus = data;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int n_vld, n_ack, ack_at, n_to;
    logic [63:0] got_d;
    logic [BW-1:0] abus1;
    logic [63:0] dbus1;
    v = vecs[idx];
    n_vld = 0; n_ack = 0; ack_at = -1; n_to = 0; got_d = '0; abus1 = '0; dbus1 = '0;
    issue(v.cfg, v.rnw, v.dw, v.addr, v.wdata);
    step();
    ha_mmval = 1'b0;
    for (int c = 1; c <= T + 8; c++) begin
      if (c == 1) begin abus1 = o_mmioabus; dbus1 = o_mmiodbus; end
      if (o_mmioabus[0]) n_vld++;
      if (ah_mmack) begin n_ack++; ack_at = c; got_d = ah_mmdata; end
      if (o_timeout) n_to++;
      i_ack_v = (c == v.ack_cyc);
      i_ack_d = v.ack_d;
      step();
    end
    i_ack_v = 1'b0;
    chk($sformatf("vec%0d abus", idx), 256'(abus1), 256'({v.addr, v.dw, v.rnw, v.cfg, 1'b1}));
    chk($sformatf("vec%0d dbus", idx), 256'(dbus1), 256'(v.wdata));
    chk($sformatf("vec%0d vld_pulses", idx), 256'(n_vld), 256'(1));
    chk($sformatf("vec%0d ack_count", idx), 256'(n_ack), 256'(1));
    chk($sformatf("vec%0d ack_cycle", idx), 256'(ack_at), 256'(v.exp_resp));
    chk($sformatf("vec%0d ack_data", idx), 256'(got_d), 256'(v.exp_data));
    chk($sformatf("vec%0d timeout_pulses", idx), 256'(n_to), 256'(v.exp_to));
  endtask

  initial begin
    obs_t exp_o;
    int busy, acc, resp_at;
    logic pr_rnw, pr_dw;

    //            cfg   rnw   dw    addr        wdata                  ack_cyc ack_d                  exp_data               resp  to
    vecs[0] = '{1'b0, 1'b1, 1'b1, 24'h000100, 64'h0,                 5,     64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 6,    0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 24'h000200, 64'h0,                 2,     64'h0000_0000_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF, 3,    0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 24'h000300, 64'h0,                 T + 1, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678, T + 2, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 24'h000010, 64'hA5A5_0000_1111_2222, 3,   64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 4,    0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 24'hFFFFFC, 64'h0,                 9,     64'hAAAA_BBBB_1234_5678, 64'h1234_5678_1234_5678, 10,   0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 24'h000400, 64'h0,                 -1,    64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, T + 2, 1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 24'h000020, 64'h0,                 -1,    64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, T + 2, 1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 24'h804900, 64'h55,                -1,    64'h0,                 64'h0,                 T + 2, 1};

    // ---- reset state ----
    step(); step(); step();
    chk("reset_outputs", 256'(get_obs()), 256'(0));
    rst_n = 1'b1;
    step();

    // ---- directed transaction table ----
    for (int i = 0; i < 8; i++) run_vec(i);

    // ---- late ack after the timed-out write: stray pulse, no host ack ----
    i_ack_v = 1'b1;
    step();
    i_ack_v = 1'b0;
    chk("stray_pulse", 256'(o_stray_ack), 256'(1));
    chk("stray_no_mmack", 256'(ah_mmack), 256'(0));
    step();
    chk("stray_one_cycle", 256'(o_stray_ack), 256'(0));

    // ---- second request during WAIT ----
    begin
      int perr_at, n_perr, n_vld, n_ack, ack_at;
      logic [63:0] d;
      perr_at = -1; n_perr = 0; n_vld = 0; n_ack = 0; ack_at = -1; d = '0;
      issue(1'b0, 1'b1, 1'b0, 24'h000042, 64'h0F0F_0F0F_0F0F_0F0F);
      step();
      ha_mmval = 1'b0;
      for (int c = 1; c <= T + 8; c++) begin
        if (o_mmioabus[0]) n_vld++;
        if (o_proto_err) begin n_perr++; perr_at = c; end
        if (ah_mmack) begin n_ack++; ack_at = c; d = ah_mmdata; end
        ha_mmval = (c == 3);
        if (c == 3) begin
          ha_mmad = 24'h000999; ha_mmrnw = 1'b0; ha_mmcfg = 1'b1; ha_mmdata = 64'hBAD;
        end
        i_ack_v = (c == 6);
        i_ack_d = 64'h5555_6666_7777_8888;
        step();
      end
      ha_mmval = 1'b0; i_ack_v = 1'b0;
      chk("perr_cycle", 256'(perr_at), 256'(4));
      chk("perr_count", 256'(n_perr), 256'(1));
      chk("busy_vld_pulses", 256'(n_vld), 256'(1));
      chk("busy_ack_count", 256'(n_ack), 256'(1));
      chk("busy_ack_cycle", 256'(ack_at), 256'(7));
      chk("busy_ack_data", 256'(d), 256'(64'h7777_8888_7777_8888));
      chk("busy_abus_held", 256'(o_mmioabus), 256'({24'h000042, 1'b0, 1'b1, 1'b0, 1'b0}));
      chk("busy_dbus_held", 256'(o_mmiodbus), 256'(64'h0F0F_0F0F_0F0F_0F0F));
    end

    // ---- reset asserted during WAIT ----
    begin
      int n_ack;
      n_ack = 0;
      issue(1'b1, 1'b1, 1'b1, 24'h00ABCD, 64'h1111_2222_3333_4444);
      step();
      ha_mmval = 1'b0;
      step(); step();            // cycle 3: WAIT
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_outputs", 256'(get_obs()), 256'(0));
      last_abus = '0; last_dbus = '0;
      i_ack_v = 1'b1;
      step();
      i_ack_v = 1'b0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < T + 6; c++) begin
        step();
        if (ah_mmack) n_ack++;
      end
      chk("midreset_no_mmack", 256'(n_ack), 256'(0));
    end
    vecs[0] = '{1'b0, 1'b1, 1'b1, 24'h001234, 64'h0, 2, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9, 3, 0};
    run_vec(0);

    // ---- randomized run against a transaction-level model ----
    // Cycle t is when inputs are presented; the model predicts cycle t+1.
    // A request accepted at cycle acc: ISSUE at acc+1, waiting from acc+2;
    // first ack at cycle n answers at n+1, else forced answer at acc+T+2.
    busy = 0; acc = 0; resp_at = -1; pr_rnw = 1'b0; pr_dw = 1'b0;
    for (int t = 0; t < N_RAND; t++) begin
      ha_mmval  = ($urandom_range(0, 3) == 0);
      ha_mmcfg  = 1'($urandom);
      ha_mmrnw  = 1'($urandom);
      ha_mmdw   = 1'($urandom);
      ha_mmad   = AW'($urandom);
      ha_mmdata = {$urandom, $urandom};
      i_ack_v   = ($urandom_range(0, 39) == 0);
      i_ack_d   = {$urandom, $urandom};

      exp_o = '0;
      if (busy == 0) begin
        exp_o.stray = i_ack_v;
        if (ha_mmval) begin
          busy = 1; acc = t; resp_at = -1;
          pr_rnw = ha_mmrnw; pr_dw = ha_mmdw;
          last_abus = {ha_mmad, ha_mmdw, ha_mmrnw, ha_mmcfg, 1'b0};
          last_dbus = ha_mmdata;
          exp_o.abus = last_abus | BW'(1);
        end
      end else begin
        exp_o.perr = ha_mmval;
        if (t == resp_at) begin
          busy = 0;
        end else if (t >= acc + 2 && resp_at < 0) begin
          if (i_ack_v) begin
            resp_at = t + 1; exp_o.ack = 1'b1;
            exp_o.data = ref_fmt(pr_rnw, pr_dw, i_ack_d);
          end else if (t == acc + 1 + T) begin
            resp_at = t + 1; exp_o.ack = 1'b1; exp_o.to = 1'b1;
            exp_o.data = ref_fmt(pr_rnw, pr_dw, 64'hFFFF_FFFF_FFFF_FFFF);
          end
        end
      end
      if (exp_o.abus == '0) exp_o.abus = last_abus;
      exp_o.dbus = last_dbus;

      step();
      chk($sformatf("rand_cycle%0d", t), 256'(get_obs()), 256'(exp_o));
    end
    ha_mmval = 1'b0; i_ack_v = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
